sr_bank_sync: RTL and testbench



---
 rtl/sr_bank_pkg.sv | 30 +++
 rtl/sr_cell.sv | 45 ++++
 rtl/sr_bank_sync.sv | 68 ++++++
 tb/tb_sr_bank_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the synchronous set/reset bank: S=R=1 resolution modes
// and the per-channel next-state rule.
package sr_bank_pkg;

   localparam int unsigned SR_SET_DOM = 0;
   localparam int unsigned SR_RST_DOM = 1;
   localparam int unsigned SR_TOGGLE  = 2;
   localparam int unsigned SR_HOLD    = 3;

   function automatic logic sr_next_q(input logic s, input logic r, input logic q,
                                      input int unsigned mode);
      logic nq;
      nq = q;
      case ({s, r})
         2'b10: nq = 1'b1;
         2'b01: nq = 1'b0;
         2'b11: begin
            case (mode)
               SR_SET_DOM: nq = 1'b1;
               SR_RST_DOM: nq = 1'b0;
               SR_TOGGLE:  nq = ~q;
               default:    nq = q;
            endcase
         end
         default: nq = q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/sr_cell.sv
// One storage channel: registered q plus its sticky S=R=1 conflict flag.
module sr_cell
   import sr_bank_pkg::*;
#(
   parameter int unsigned MODE = SR_SET_DOM,
   parameter logic        INIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic s,
   input  logic r,
   input  logic clr_flag,
   output logic q,
   output logic conflict,
   output logic conflict_ev
);

   logic q_q, q_d;
   logic flag_q, flag_d;

   assign conflict_ev = en & s & r;

   always_comb begin
      q_d    = en ? sr_next_q(s, r, q_q, MODE) : q_q;
      flag_d = flag_q;
      if (clr_flag)    flag_d = 1'b0;
      // a fresh conflict outranks a simultaneous clear
      if (conflict_ev) flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= INIT;
         flag_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         flag_q <= flag_d;
      end
   end

   assign q        = q_q;
   assign conflict = flag_q;

endmodule

// File: rtl/sr_bank_sync.sv
// Bank of N synchronous set/reset cells with sticky conflict flags and a
// saturating count of cycles on which any channel saw S=R=1.
module sr_bank_sync
   import sr_bank_pkg::*;
#(
   parameter int unsigned     N     = 8,
   parameter int unsigned     MODE  = SR_SET_DOM,
   parameter int unsigned     CNT_W = 8,
   parameter logic [N-1:0]    INIT  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     s,
   input  logic [N-1:0]     r,
   input  logic             clr_flag,
   output logic [N-1:0]     q,
   output logic [N-1:0]     qbar,
   output logic [N-1:0]     conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   if (MODE > SR_HOLD) begin : g_bad_mode
      $error("sr_bank_sync: MODE must be 0..3");
   end

   logic [N-1:0]     ev;
   logic             any_ev;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   for (genvar i = 0; i < N; i++) begin : g_cell
      sr_cell #(
         .MODE (MODE),
         .INIT (INIT[i])
      ) u_cell (
         .clk         (clk),
         .rst         (rst),
         .en          (en),
         .s           (s[i]),
         .r           (r[i]),
         .clr_flag    (clr_flag),
         .q           (q[i]),
         .conflict    (conflict[i]),
         .conflict_ev (ev[i])
      );
   end

   assign any_ev = |ev;

   always_comb begin
      cnt_d = cnt_q;
      if (any_ev) begin
         if (clr_flag)          cnt_d = CNT_W'(1);
         else if (cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
      end else if (clr_flag) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign conflict_cnt = cnt_q;
   assign qbar         = ~q;

endmodule

// File: tb/tb_sr_bank_sync.sv
// Scoreboard bench: four banks (one per MODE, varied counter widths) share one
// stimulus stream and are checked against a vector-level reference model.
module tb_sr_bank_sync;

   localparam logic [7:0] INIT_V = 8'hA5;

   typedef struct packed {
      logic [3:0][7:0] q;
      logic [3:0][7:0] fl;
      logic [3:0][7:0] cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] s = '0;
   logic [7:0] r = '0;
   logic       clr_flag = 1'b0;

   logic [7:0] q_a  [4];
   logic [7:0] qb_a [4];
   logic [7:0] cf_a [4];
   logic [7:0] cnt0;
   logic [1:0] cnt1;
   logic [7:0] cnt2;
   logic [2:0] cnt3;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   logic [7:0]  mq  [4];
   logic [7:0]  mfl [4];
   int unsigned mcnt[4];

   always #5 clk = ~clk;

   sr_bank_sync #(.N(8), .MODE(0), .CNT_W(8), .INIT(INIT_V)) u_m0 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
      .q(q_a[0]), .qbar(qb_a[0]), .conflict(cf_a[0]), .conflict_cnt(cnt0));
   sr_bank_sync #(.N(8), .MODE(1), .CNT_W(2), .INIT(INIT_V)) u_m1 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
      .q(q_a[1]), .qbar(qb_a[1]), .conflict(cf_a[1]), .conflict_cnt(cnt1));
   sr_bank_sync #(.N(8), .MODE(2), .CNT_W(8), .INIT(INIT_V)) u_m2 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
      .q(q_a[2]), .qbar(qb_a[2]), .conflict(cf_a[2]), .conflict_cnt(cnt2));
   sr_bank_sync #(.N(8), .MODE(3), .CNT_W(3), .INIT(INIT_V)) u_m3 (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_flag(clr_flag),
      .q(q_a[3]), .qbar(qb_a[3]), .conflict(cf_a[3]), .conflict_cnt(cnt3));

   function automatic int unsigned cnt_max(input int d);
      case (d)
         1:       return 3;
         3:       return 7;
         default: return 255;
      endcase
   endfunction

   // Drive one cycle of stimulus and push the state expected after that edge.
   task automatic cyc(input logic a_rst, input logic a_en, input logic [7:0] a_s,
                      input logic [7:0] a_r, input logic a_clr);
      exp_t       e;
      logic [7:0] ev, both;
      @(negedge clk);
      rst = a_rst; en = a_en; s = a_s; r = a_r; clr_flag = a_clr;
      for (int d = 0; d < 4; d++) begin
         if (a_rst) begin
            mq[d] = INIT_V; mfl[d] = '0; mcnt[d] = 0;
         end else begin
            ev = a_en ? (a_s & a_r) : 8'h00;
            if (a_en) begin
               both  = a_s & a_r;
               mq[d] = (mq[d] | (a_s & ~a_r)) & ~(a_r & ~a_s);
               case (d)
                  0: mq[d] = mq[d] | both;
                  1: mq[d] = mq[d] & ~both;
                  2: mq[d] = mq[d] ^ both;
                  default: ;
               endcase
            end
            mfl[d] = a_clr ? ev : (mfl[d] | ev);
            if (ev != 0)   mcnt[d] = a_clr ? 1 : ((mcnt[d] < cnt_max(d)) ? mcnt[d] + 1 : mcnt[d]);
            else if (a_clr) mcnt[d] = 0;
         end
         e.q[d]   = mq[d];
         e.fl[d]  = mfl[d];
         e.cnt[d] = 8'(mcnt[d]);
      end
      sbq.push_back(e);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [7:0] ca;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int d = 0; d < 4; d++) begin
               case (d)
                  0: ca = cnt0;
                  1: ca = {6'b0, cnt1};
                  2: ca = cnt2;
                  default: ca = {5'b0, cnt3};
               endcase
               checks++;
               if (q_a[d] !== e.q[d]) begin
                  errors++;
                  $display("FAIL q[m%0d] got %h want %h @%0t", d, q_a[d], e.q[d], $time);
               end
               checks++;
               if (qb_a[d] !== ~e.q[d]) begin
                  errors++;
                  $display("FAIL qbar[m%0d] got %h want %h @%0t", d, qb_a[d], ~e.q[d], $time);
               end
               checks++;
               if (cf_a[d] !== e.fl[d]) begin
                  errors++;
                  $display("FAIL conflict[m%0d] got %h want %h @%0t", d, cf_a[d], e.fl[d], $time);
               end
               checks++;
               if (ca !== e.cnt[d]) begin
                  errors++;
                  $display("FAIL cnt[m%0d] got %0d want %0d @%0t", d, ca, e.cnt[d], $time);
               end
            end
         end
      end
   end

   initial begin : stim
      for (int d = 0; d < 4; d++) begin
         mq[d] = INIT_V; mfl[d] = '0; mcnt[d] = 0;
      end
      cyc(1, 0, 8'h00, 8'h00, 0);
      cyc(1, 0, 8'h00, 8'h00, 0);
      cyc(0, 0, 8'hFF, 8'h00, 0);
      cyc(0, 0, 8'hFF, 8'hFF, 0);
      cyc(0, 1, 8'h00, 8'hFF, 0);
      cyc(0, 1, 8'h0F, 8'hF0, 0);
      cyc(0, 1, 8'h01, 8'h01, 0);
      cyc(0, 0, 8'h00, 8'h00, 1);
      repeat (3) cyc(0, 1, 8'h01, 8'h01, 0);
      cyc(0, 0, 8'h00, 8'h00, 1);
      repeat (5) cyc(0, 1, 8'h09, 8'h09, 0);
      cyc(0, 1, 8'h04, 8'h04, 1);
      cyc(0, 0, 8'h00, 8'h00, 1);
      cyc(0, 1, 8'h80, 8'h80, 0);
      cyc(1, 1, 8'hFF, 8'h00, 0);
      cyc(1, 1, 8'hFF, 8'hFF, 0);
      cyc(0, 1, 8'hFF, 8'hFF, 0);
      for (int i = 0; i < 400; i++) begin
         logic [7:0] rs, rr;
         rs = 8'($urandom);
         rr = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rr = rs;
         cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rs, rr,
             ($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < 8 && sbq.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain left %0d want 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
